// File: rtl/lc3b_types.sv
// Shared LC-3b types: data word, byte write mask and the memory arbiter state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } lc3b_arb_state;

endpackage

// File: rtl/lc3b_arb_watchdog.sv
// Wait-cycle counter for the granted memory transaction with a sticky timeout flag.
// WAIT_LIMIT = 0 disables the flag; the counter saturates instead of wrapping.
module lc3b_arb_watchdog #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic busy,
  output logic timeout_err
);

  localparam int CW = 16;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Flag rises on the edge where the count reaches the limit, not one cycle later.
    if ((WAIT_LIMIT != 0) && busy && !clear && (cnt_d >= CW'(WAIT_LIMIT))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Single-port memory arbiter between LC-3b instruction fetch (I) and data access (D).
// Build option ARB_ROUND_ROBIN_EN: alternate winner on contention instead of D-over-I priority.
module lc3b_mem_arbiter
  import lc3b_types::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_read,
  input  lc3b_word      i_address,
  output logic          i_resp,
  output lc3b_word      i_rdata,
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_word      d_address,
  input  lc3b_word      d_wdata,
  input  lc3b_mem_wmask d_wmask,
  output logic          d_resp,
  output lc3b_word      d_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_word      mem_address,
  output lc3b_word      mem_wdata,
  output lc3b_mem_wmask mem_wmask,
  input  logic          mem_resp,
  input  lc3b_word      mem_rdata,
  output logic          timeout_err
);

  lc3b_arb_state state_q, state_d;
  logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  lc3b_word      addr_q, addr_d, wdata_q, wdata_d;
  lc3b_mem_wmask wmask_q, wmask_d;
  logic          i_resp_q, i_resp_d, d_resp_q, d_resp_d;
  lc3b_word      i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          d_req, pick_d, pick_i;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // last_q = 0: I served last, so D wins a tie; 1: D served last, so I wins.
  logic last_q, last_d;
  assign pick_d = d_req && (!i_read || !last_q);
`else
  assign pick_d = d_req;
`endif
  assign pick_i = i_read && !pick_d;

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    i_resp_d    = 1'b0;
    d_resp_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Simultaneous read and write from D is a protocol error; the write wins.
        if (pick_d) begin
          state_d     = D_BUSY;
          mem_write_d = d_write;
          mem_read_d  = !d_write;
          addr_d      = d_address;
          wdata_d     = d_wdata;
          wmask_d     = d_write ? d_wmask : 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
          last_d      = 1'b1;
`endif
        end else if (pick_i) begin
          state_d     = I_BUSY;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          addr_d      = i_address;
          wdata_d     = '0;
          wmask_d     = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
          last_d      = 1'b0;
`endif
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (state_q == I_BUSY) begin
            i_resp_d  = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_resp_d  = 1'b1;
            d_rdata_d = mem_rdata;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      i_resp_q    <= i_resp_d;
      d_resp_q    <= d_resp_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  lc3b_arb_watchdog #(.WAIT_LIMIT(WAIT_LIMIT)) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .clear       ((state_q == IDLE) && (pick_d || pick_i)),
    .busy        ((state_q == I_BUSY) || (state_q == D_BUSY)),
    .timeout_err (timeout_err)
  );

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wmask   = wmask_q;
  assign i_resp      = i_resp_q;
  assign d_resp      = d_resp_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed bench for lc3b_mem_arbiter (default fixed-priority build, WAIT_LIMIT = 4).
module tb_lc3b_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read;
  logic [15:0] i_address;
  logic        i_resp;
  logic [15:0] i_rdata;
  logic        d_read, d_write;
  logic [15:0] d_address, d_wdata;
  logic [1:0]  d_wmask;
  logic        d_resp;
  logic [15:0] d_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_wmask;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;

  lc3b_mem_arbiter #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0; d_wmask = '0;
    mem_resp = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_read", {15'd0, mem_read}, 16'd0);
    chk("rst_mem_write", {15'd0, mem_write}, 16'd0);
    chk("rst_mem_address", mem_address, 16'h0000);
    chk("rst_resp", {14'd0, i_resp, d_resp}, 16'd0);
    chk("rst_rdata", i_rdata | d_rdata, 16'h0000);
    chk("rst_timeout", {15'd0, timeout_err}, 16'd0);
    reset = 1'b0;
    tick();

    // Single fetch, memory answers after three strobe cycles.
    i_read = 1'b1; i_address = 16'h0040;
    tick();
    chk("t1_mem_read_c1", {15'd0, mem_read}, 16'd1);
    chk("t1_addr_c1", mem_address, 16'h0040);
    i_read = 1'b0; i_address = 16'hDEAD;
    tick();
    chk("t1_mem_read_c2", {15'd0, mem_read}, 16'd1);
    tick();
    chk("t1_mem_read_c3", {15'd0, mem_read}, 16'd1);
    chk("t1_addr_c3", mem_address, 16'h0040);
    chk("t1_no_early_resp", {15'd0, i_resp}, 16'd0);
    mem_resp = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    chk("t1_i_resp", {15'd0, i_resp}, 16'd1);
    chk("t1_i_rdata", i_rdata, 16'h1234);
    chk("t1_d_resp", {15'd0, d_resp}, 16'd0);
    chk("t1_strobe_drop", {15'd0, mem_read}, 16'd0);
    tick();
    chk("t1_resp_one_cycle", {15'd0, i_resp}, 16'd0);
    chk("t1_rdata_hold", i_rdata, 16'h1234);
    chk("t1_timeout", {15'd0, timeout_err}, 16'd0);

    // Contention: D write beats the fetch; fetch follows.
    i_read = 1'b1; i_address = 16'h0200;
    d_write = 1'b1; d_address = 16'h0100; d_wdata = 16'hBEEF; d_wmask = 2'b01;
    tick();
    chk("t2_mem_write", {15'd0, mem_write}, 16'd1);
    chk("t2_mem_read", {15'd0, mem_read}, 16'd0);
    chk("t2_addr", mem_address, 16'h0100);
    chk("t2_wdata", mem_wdata, 16'hBEEF);
    chk("t2_wmask", {14'd0, mem_wmask}, 16'h0001);
    d_write = 1'b0; d_wmask = 2'b11; d_wdata = 16'h0000;
    mem_resp = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    chk("t2_d_resp", {15'd0, d_resp}, 16'd1);
    chk("t2_i_resp", {15'd0, i_resp}, 16'd0);
    chk("t2_d_rdata", d_rdata, 16'h5555);
    chk("t2_write_drop", {15'd0, mem_write}, 16'd0);
    tick();
    chk("t2_done_no_grant", {15'd0, mem_read}, 16'd0);
    tick();
    chk("t2_i_grant", {15'd0, mem_read}, 16'd1);
    chk("t2_i_addr", mem_address, 16'h0200);
    chk("t2_i_wmask", {14'd0, mem_wmask}, 16'h0000);
    mem_resp = 1'b1; mem_rdata = 16'hABCD;
    tick();
    mem_resp = 1'b0;
    chk("t2_i_resp_pulse", {15'd0, i_resp}, 16'd1);
    chk("t2_i_rdata", i_rdata, 16'hABCD);

    // Back-to-back fetches, i_read held: grant period of four cycles.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_idle_no_strobe", {15'd0, mem_read}, 16'd0);
      chk("t3_idle_no_resp", {15'd0, i_resp}, 16'd0);
      tick();
      chk("t3_grant", {15'd0, mem_read}, 16'd1);
      tick();
      chk("t3_busy", {15'd0, mem_read}, 16'd1);
      chk("t3_busy_no_resp", {15'd0, i_resp}, 16'd0);
      mem_resp = 1'b1; mem_rdata = 16'h1000 + 16'(k);
      tick();
      mem_resp = 1'b0;
      chk("t3_resp", {15'd0, i_resp}, 16'd1);
      chk("t3_rdata", i_rdata, 16'h1000 + 16'(k));
      if (k == 2) i_read = 1'b0;
    end
    tick();
    tick();
    chk("t3_no_extra_grant", {15'd0, mem_read}, 16'd0);

    // Spurious mem_resp while idle.
    mem_resp = 1'b1; mem_rdata = 16'hFFFF;
    tick();
    mem_resp = 1'b0;
    chk("t6_no_resp", {14'd0, i_resp, d_resp}, 16'd0);
    chk("t6_i_rdata_hold", i_rdata, 16'h1002);
    chk("t6_d_rdata_hold", d_rdata, 16'h5555);
    tick();
    chk("t6_still_idle", {14'd0, mem_read, mem_write}, 16'd0);

    // Reset during D_BUSY, pending fetch served afterwards.
    d_read = 1'b1; d_address = 16'h0300; i_read = 1'b1; i_address = 16'h0200;
    tick();
    chk("t5_d_grant", {14'd0, mem_read, mem_write}, 16'h0002);
    chk("t5_d_addr", mem_address, 16'h0300);
    d_read = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_strobes_low", {14'd0, mem_read, mem_write}, 16'd0);
    chk("t5_no_d_resp", {15'd0, d_resp}, 16'd0);
    chk("t5_addr_cleared", mem_address, 16'h0000);
    tick();
    chk("t5_i_grant", {15'd0, mem_read}, 16'd1);
    chk("t5_i_addr", mem_address, 16'h0200);
    i_read = 1'b0;
    mem_resp = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_resp = 1'b0;
    chk("t5_i_resp", {14'd0, i_resp, d_resp}, 16'h0002);
    chk("t5_i_rdata", i_rdata, 16'h7777);
    tick();

    // Watchdog: no response, flag after four busy cycles, sticky until reset.
    i_read = 1'b1; i_address = 16'h0444;
    tick();
    i_read = 1'b0;
    chk("t4_grant", {15'd0, mem_read}, 16'd1);
    tick(); tick(); tick();
    chk("t4_not_yet", {15'd0, timeout_err}, 16'd0);
    tick();
    chk("t4_timeout_set", {15'd0, timeout_err}, 16'd1);
    tick(); tick();
    chk("t4_timeout_sticky", {15'd0, timeout_err}, 16'd1);
    chk("t4_still_reading", {15'd0, mem_read}, 16'd1);
    chk("t4_addr_held", mem_address, 16'h0444);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_reset_timeout", {15'd0, timeout_err}, 16'd0);
    chk("t4_reset_strobe", {15'd0, mem_read}, 16'd0);
    chk("t4_reset_rdata", i_rdata, 16'h0000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
